// File: rtl/color_sequence_checker_if.sv
// Bus between a color-sequence checker and whatever drives the challenge:
// round control, player guesses and the round status/result outputs.
interface color_sequence_checker_if;
   logic        start;
   logic [14:0] seq_colors;
   logic        guess_valid;
   logic [2:0]  guess_color;
   logic        busy;
   logic [2:0]  expect_color;
   logic [2:0]  index;
   logic [2:0]  score;
   logic        done;
   logic        pass;
   logic [1:0]  fail_reason;

   // Game controller / player side.
   modport master (
      output start, seq_colors, guess_valid, guess_color,
      input  busy, expect_color, index, score, done, pass, fail_reason
   );

   // Checker side.
   modport slave (
      input  start, seq_colors, guess_valid, guess_color,
      output busy, expect_color, index, score, done, pass, fail_reason
   );
endinterface

// File: rtl/color_sequence_checker.sv
// Color sequence checker: latches a challenge of SEQ_LEN color codes on start,
// then grades the player's guesses one at a time, ending the round on the
// first wrong/invalid guess, an idle timeout, or after the last correct guess.
module color_sequence_checker #(
   parameter int unsigned SEQ_LEN        = 5,
   parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
   input  logic                      clk,
   input  logic                      rst,
   color_sequence_checker_if.slave   bus
);

   localparam int unsigned COLOR_W  = 3;
   localparam int unsigned SEQ_W    = COLOR_W * SEQ_LEN;
   localparam int unsigned TIMER_W  = $clog2(TIMEOUT_CYCLES);

   localparam logic [2:0] LAST_IDX = 3'(SEQ_LEN - 1);
   // Timeout fires on the idle edge that would bring the timer to TIMEOUT_CYCLES-1.
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 2);

   localparam logic [1:0] REASON_NONE     = 2'b00;
   localparam logic [1:0] REASON_MISMATCH = 2'b01;
   localparam logic [1:0] REASON_TIMEOUT  = 2'b10;
   localparam logic [1:0] REASON_INVALID  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_FINISH = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [SEQ_W-1:0]     seq_q, seq_d;
   logic [2:0]           index_q, index_d;
   logic [2:0]           score_q, score_d;
   logic                 pass_q, pass_d;
   logic [1:0]           fail_reason_q, fail_reason_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [2:0]           expect_color_q, expect_color_d;

   logic [2:0]           cur_color_c;
   logic                 color_invalid_c;
   logic                 color_match_c;
   logic                 timeout_c;

   // Pick challenge entry i out of a packed sequence (entry 0 in the low bits).
   function automatic logic [2:0] entry_at(input logic [SEQ_W-1:0] s, input logic [2:0] i);
      logic [2:0] e;
      e = '0;
      for (int k = 0; k < int'(SEQ_LEN); k++) begin
         if (i == 3'(k)) e = s[COLOR_W*k +: COLOR_W];
      end
      return e;
   endfunction

   // Guess classification and idle-timeout detection for the current position.
   always_comb begin
      cur_color_c     = entry_at(seq_q, index_q);
      color_invalid_c = (bus.guess_color == 3'b000) || (bus.guess_color == 3'b111);
      color_match_c   = (bus.guess_color == cur_color_c);
      timeout_c       = (timer_q == TIMER_LAST);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.guess_valid) begin
               if (color_invalid_c || !color_match_c) state_d = S_FINISH;
               else if (index_q == LAST_IDX)          state_d = S_FINISH;
            end else if (timeout_c) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values.
   always_comb begin
      seq_d         = seq_q;
      index_d       = index_q;
      score_d       = score_q;
      pass_d        = pass_q;
      fail_reason_d = fail_reason_q;
      timer_d       = timer_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               seq_d         = SEQ_W'(bus.seq_colors);
               index_d       = '0;
               score_d       = '0;
               pass_d        = 1'b0;
               fail_reason_d = REASON_NONE;
               timer_d       = '0;
            end
         end
         S_WAIT: begin
            if (bus.guess_valid) begin
               if (color_invalid_c) begin
                  fail_reason_d = REASON_INVALID;
               end else if (!color_match_c) begin
                  fail_reason_d = REASON_MISMATCH;
               end else begin
                  score_d = score_q + 3'd1;
                  timer_d = '0;
                  if (index_q == LAST_IDX) pass_d  = 1'b1;
                  else                     index_d = index_q + 3'd1;
               end
            end else if (timeout_c) begin
               fail_reason_d = REASON_TIMEOUT;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         default: ;
      endcase
      busy_d         = (state_d == S_WAIT);
      done_d         = (state_d == S_FINISH);
      expect_color_d = busy_d ? entry_at(seq_d, index_d) : 3'b000;
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         seq_q          <= '0;
         index_q        <= '0;
         score_q        <= '0;
         pass_q         <= 1'b0;
         fail_reason_q  <= REASON_NONE;
         timer_q        <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         expect_color_q <= '0;
      end else begin
         seq_q          <= seq_d;
         index_q        <= index_d;
         score_q        <= score_d;
         pass_q         <= pass_d;
         fail_reason_q  <= fail_reason_d;
         timer_q        <= timer_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         expect_color_q <= expect_color_d;
      end
   end

   assign bus.busy         = busy_q;
   assign bus.expect_color = expect_color_q;
   assign bus.index        = index_q;
   assign bus.score        = score_q;
   assign bus.done         = done_q;
   assign bus.pass         = pass_q;
   assign bus.fail_reason  = fail_reason_q;

endmodule

// File: tb/tb_color_sequence_checker.sv
// Directed bench for color_sequence_checker: round results are queued when the
// deciding stimulus is driven and compared when done pulses.
module tb_color_sequence_checker;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   color_sequence_checker_if bus();

   color_sequence_checker #(
      .SEQ_LEN        (5),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic       pass;
      logic [2:0] score;
      logic [2:0] index;
      logic [1:0] fail;
   } result_t;

   localparam logic [2:0] PUR = 3'b001;
   localparam logic [2:0] ORA = 3'b010;
   localparam logic [2:0] YEL = 3'b011;
   localparam logic [2:0] BLU = 3'b100;
   localparam logic [2:0] RED = 3'b101;
   localparam logic [2:0] GRN = 3'b110;

   result_t    exp_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   logic [2:0] seq_a [5];
   logic [2:0] seq_b [5];

   function automatic logic [14:0] pack_seq(input logic [2:0] s [5]);
      return {s[4], s[3], s[2], s[1], s[0]};
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic b, input logic [2:0] e,
                           input logic [2:0] i, input logic [2:0] s, input logic d,
                           input logic p, input logic [1:0] f);
      chk({tag, ".busy"},   32'(bus.busy),         32'(b));
      chk({tag, ".expect"}, 32'(bus.expect_color), 32'(e));
      chk({tag, ".index"},  32'(bus.index),        32'(i));
      chk({tag, ".score"},  32'(bus.score),        32'(s));
      chk({tag, ".done"},   32'(bus.done),         32'(d));
      chk({tag, ".pass"},   32'(bus.pass),         32'(p));
      chk({tag, ".reason"}, 32'(bus.fail_reason),  32'(f));
   endtask

   task automatic pulse_start(input logic [14:0] seq);
      bus.seq_colors = seq;
      bus.start      = 1'b1;
      tick(1);
      bus.start      = 1'b0;
   endtask

   task automatic guess(input logic [2:0] c);
      bus.guess_valid = 1'b1;
      bus.guess_color = c;
      tick(1);
      bus.guess_valid = 1'b0;
   endtask

   // Scoreboard: every done pulse must match the oldest queued round result.
   always @(posedge clk) begin
      #1;
      if (bus.done === 1'b1) begin
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL unexpected_done observed=done_pulse expected=no_pulse");
         end
         if (exp_q.size() != 0) begin
            result_t e;
            result_t o;
            e = exp_q.pop_front();
            o = {bus.pass, bus.score, bus.index, bus.fail_reason};
            chk("sb_result", 32'(o), 32'(e));
            chk("sb_busy", 32'(bus.busy), 32'(0));
         end
      end
   end

   initial begin
      rst             = 1'b1;
      bus.start       = 1'b0;
      bus.seq_colors  = 15'h7fff;
      bus.guess_valid = 1'b0;
      bus.guess_color = 3'b000;
      seq_a = '{PUR, ORA, YEL, BLU, RED};
      seq_b = '{GRN, RED, BLU, YEL, ORA};

      tick(2);
      chk_outs("reset", 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
      rst = 1'b0;
      tick(1);
      chk_outs("idle", 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);

      // Full correct round, guesses two cycles apart; seq input changes after start.
      pulse_start(pack_seq(seq_a));
      bus.seq_colors = 15'h5555;
      chk_outs("a_start", 1'b1, PUR, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
      for (int i = 0; i < 5; i++) begin
         if (i == 4) exp_q.push_back({1'b1, 3'd5, 3'd4, 2'b00});
         guess(seq_a[i]);
         if (i < 4) begin
            chk_outs($sformatf("a_g%0d", i), 1'b1, seq_a[i+1], 3'(i+1), 3'(i+1),
                     1'b0, 1'b0, 2'b00);
            tick(1);
         end else begin
            chk_outs("a_end", 1'b0, 3'd0, 3'd4, 3'd5, 1'b1, 1'b1, 2'b00);
         end
      end
      tick(1);
      chk_outs("a_hold", 1'b0, 3'd0, 3'd4, 3'd5, 1'b0, 1'b1, 2'b00);

      // Mismatch on the third guess.
      pulse_start(pack_seq(seq_a));
      chk_outs("b_start", 1'b1, PUR, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
      guess(PUR);
      guess(ORA);
      exp_q.push_back({1'b0, 3'd2, 3'd2, 2'b01});
      guess(GRN);
      chk_outs("b_end", 1'b0, 3'd0, 3'd2, 3'd2, 1'b1, 1'b0, 2'b01);
      tick(1);
      chk_outs("b_hold", 1'b0, 3'd0, 3'd2, 3'd2, 1'b0, 1'b0, 2'b01);

      // Pure timeout: done in the 8th cycle after the start cycle.
      exp_q.push_back({1'b0, 3'd0, 3'd0, 2'b10});
      pulse_start(pack_seq(seq_a));
      tick(6);
      chk_outs("c_wait", 1'b1, PUR, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
      tick(1);
      chk_outs("c_timeout", 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 2'b10);
      tick(1);

      // Guess in the last allowed cycle is accepted and restarts the timer.
      pulse_start(pack_seq(seq_a));
      tick(6);
      guess(PUR);
      chk_outs("c2_late_guess", 1'b1, ORA, 3'd1, 3'd1, 1'b0, 1'b0, 2'b00);
      exp_q.push_back({1'b0, 3'd1, 3'd1, 2'b10});
      tick(6);
      chk_outs("c2_wait", 1'b1, ORA, 3'd1, 3'd1, 1'b0, 1'b0, 2'b00);
      tick(1);
      chk_outs("c2_timeout", 1'b0, 3'd0, 3'd1, 3'd1, 1'b1, 1'b0, 2'b10);
      tick(1);

      // Start mid-round ignored; invalid code wins; start in FINISH and idle guesses ignored.
      pulse_start(pack_seq(seq_a));
      pulse_start(pack_seq(seq_b));
      chk_outs("d_restart_ignored", 1'b1, PUR, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
      exp_q.push_back({1'b0, 3'd0, 3'd0, 2'b11});
      guess(3'b111);
      chk_outs("d_invalid", 1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 2'b11);
      pulse_start(pack_seq(seq_b));
      chk_outs("d_start_in_finish", 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b11);
      guess(PUR);
      chk_outs("d_guess_idle", 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b11);

      // Reset mid-round dominates start/guess, then a clean back-to-back round.
      pulse_start(pack_seq(seq_a));
      guess(PUR);
      guess(ORA);
      chk_outs("e_two", 1'b1, YEL, 3'd2, 3'd2, 1'b0, 1'b0, 2'b00);
      rst             = 1'b1;
      bus.start       = 1'b1;
      bus.guess_valid = 1'b1;
      bus.guess_color = YEL;
      tick(1);
      rst             = 1'b0;
      bus.start       = 1'b0;
      bus.guess_valid = 1'b0;
      chk_outs("e_reset", 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
      tick(1);
      chk_outs("e_after", 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
      pulse_start(pack_seq(seq_b));
      chk_outs("e_start", 1'b1, GRN, 3'd0, 3'd0, 1'b0, 1'b0, 2'b00);
      exp_q.push_back({1'b1, 3'd5, 3'd4, 2'b00});
      for (int i = 0; i < 5; i++) guess(seq_b[i]);
      chk_outs("e_end", 1'b0, 3'd0, 3'd4, 3'd5, 1'b1, 1'b1, 2'b00);
      tick(2);

      chk("sb_drained", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/color_sequence_checker.md
COLOR_SEQUENCE_CHECKER -- requirements
Module: color_sequence_checker

Interface
REQ-001 Parameter SEQ_LEN, default 5, number of colors in one challenge sequence (fixed at 5; other values unsupported).
REQ-002 Parameter TIMEOUT_CYCLES, default 25_000_000, maximum idle clk cycles allowed between guesses (must be ≥2).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; latch sequence and begin a round.
REQ-006 seq_colors  input  15  challenge sequence; entry i at bits [3i+2:3i], entry 0 guessed first.
REQ-007 guess_valid  input  1  one-cycle pulse; player guess present on guess_color.
REQ-008 guess_color  input  3  player color code.
REQ-009 busy  output  1  high while a round is in progress.
REQ-010 expect_color  output  3  color currently expected (display/debug).
REQ-011 index  output  3  position of next expected guess, 0..4.
REQ-012 score  output  3  count of correct guesses in current/last round, 0..5.
REQ-013 done  output  1  one-cycle pulse at round end.
REQ-014 pass  output  1  level; 1 if last round completed all 5 correctly.
REQ-015 fail_reason  output  2  00 none, 01 mismatch, 10 timeout, 11 invalid color code.

Function
REQ-016 Color codes: PURPLE 001, ORANGE 010, YELLOW 011, BLUE 100, RED 101, GREEN 110; 000 and 111 are invalid.
REQ-017 States: IDLE, WAIT_GUESS, FINISH; only these three, one-hot or binary at implementer's choice.
REQ-018 IDLE + start=1: latch seq_colors into internal register, index←0, score←0, pass←0, fail_reason←00, timer←0, go WAIT_GUESS; busy=1 from next cycle.
REQ-019 start while busy=1 or in FINISH: ignored; latched sequence unchanged.
REQ-020 seq_colors sampled only on the accepted start edge; later changes have no effect on the round.
REQ-021 expect_color = latched entry[index] while busy=1, 000 otherwise.
REQ-022 WAIT_GUESS + guess_valid with invalid guess_color: fail_reason←11, go FINISH (priority over mismatch).
REQ-023 WAIT_GUESS + guess_valid, guess_color ≠ entry[index]: fail_reason←01, index/score unchanged, go FINISH.
REQ-024 WAIT_GUESS + guess_valid, guess_color = entry[index]: score+1, timer←0; if index=4 then pass←1, go FINISH (index held at 4), else index+1.
REQ-025 Timer increments each WAIT_GUESS cycle without guess_valid; on reaching TIMEOUT_CYCLES-1 with no guess: fail_reason←10, go FINISH.
REQ-026 guess_valid in the same cycle timer hits TIMEOUT_CYCLES-1: guess processed, timeout suppressed.
REQ-027 FINISH: done=1 for exactly one cycle, busy=0, then IDLE; pass, score, index, fail_reason held until next accepted start.
REQ-028 guess_valid outside WAIT_GUESS: ignored.
REQ-029 Latency: guess sampled at edge N updates score/index/state at N; done high cycle N+1.
REQ-030 score never exceeds 5; index never exceeds 4; timer width = clog2(TIMEOUT_CYCLES), no wrap.

Reset
REQ-031 rst=1 at any edge: state IDLE, busy=0, expect_color=000, index=0, score=0, done=0, pass=0, fail_reason=00, timer=0, latched sequence=0.
REQ-032 rst mid-round abandons it with no done pulse; rst dominates start and guess_valid same cycle.

Verification
REQ-033 seq {001,010,011,100,101}, start, five correct guesses 2 cycles apart -> done one cycle after 5th guess, pass=1, score=5, fail_reason=00.
REQ-034 same seq, guesses 001,010,110 -> done after 3rd guess, pass=0, score=2, index=2, fail_reason=01.
REQ-035 TIMEOUT_CYCLES=8, start, no guesses -> done at cycle 8 after start, fail_reason=10, score=0; guess at exactly cycle 7 -> accepted, no timeout.
REQ-036 guess_color=111 at index 0 -> fail_reason=11, score=0; start pulsed mid-round -> ignored, expect_color unchanged.
REQ-037 rst asserted after 2 correct guesses -> all outputs zero next cycle, no done; new start runs cleanly.
